// File: rtl/wb_port_sequencer_if.sv
// Writeback-port bundle: MEM/WB fields, auxiliary write handshake and the
// register-file write port, with master (pipeline/requester) and slave (sequencer) views.
interface wb_port_sequencer_if #(
    parameter int AW = 5
);
    // Aux handshake: AuxReq is a level held by the requester until it sees
    // AuxAck high at a rising edge; AuxAck is a one-cycle pulse that coincides
    // with the RF write slot granted to AuxDest/AuxData.
    logic          RegWrite_In;
    logic          L16B_In;
    logic [1:0]    MemToReg_In;
    logic [AW-1:0] RegDest_In;
    logic [31:0]   ALUResult_In;
    logic [31:0]   ReadData_In;
    logic [31:0]   PC_In;
    logic [127:0]  WD3_128_In;
    logic          AuxReq;
    logic [AW-1:0] AuxDest;
    logic [31:0]   AuxData;
    logic          AuxAck;
    logic          RFWrite;
    logic [AW-1:0] RFAddr;
    logic [31:0]   RFData;
    logic          Stall;

    modport master (
        output RegWrite_In, L16B_In, MemToReg_In, RegDest_In,
               ALUResult_In, ReadData_In, PC_In, WD3_128_In,
               AuxReq, AuxDest, AuxData,
        input  AuxAck, RFWrite, RFAddr, RFData, Stall
    );

    modport slave (
        input  RegWrite_In, L16B_In, MemToReg_In, RegDest_In,
               ALUResult_In, ReadData_In, PC_In, WD3_128_In,
               AuxReq, AuxDest, AuxData,
        output AuxAck, RFWrite, RFAddr, RFData, Stall
    );
endinterface

// File: rtl/wb_port_sequencer.sv
// Writeback-port sequencer: scalar writeback select, 4-beat L16B burst serialisation
// with Stall, optional aux write-slot grant when WB_AUX_PORT_EN is defined.
module wb_port_sequencer #(
    parameter int AW = 5
) (
    input  logic                Clock,
    input  logic                Reset,
    wb_port_sequencer_if.slave  bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_t;

    state_t        state, state_nx;
    logic [127:0]  burst_q, burst_nx;
    logic [AW-1:0] base_q, base_nx;
    logic          wr_q, wr_nx;
    logic [AW-1:0] addr_q, addr_nx;
    logic [31:0]   data_q, data_nx;
    logic          ack_q, ack_nx;
    logic          stall_q, stall_nx;
    logic [31:0]   sel_data;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            burst_q <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_nx;
            burst_q <= burst_nx;
            base_q  <= base_nx;
            wr_q    <= wr_nx;
            addr_q  <= addr_nx;
            data_q  <= data_nx;
            ack_q   <= ack_nx;
            stall_q <= stall_nx;
        end
    end

    always_comb begin
        state_nx = state;
        burst_nx = burst_q;
        base_nx  = base_q;
        wr_nx    = 1'b0;
        addr_nx  = addr_q;
        data_nx  = data_q;
        ack_nx   = 1'b0;

        case (bus.MemToReg_In)
            2'd1:    sel_data = bus.ReadData_In;
            2'd2:    sel_data = bus.PC_In;
            default: sel_data = bus.ALUResult_In;
        endcase

        case (state)
            IDLE: begin
                if (bus.RegWrite_In && bus.L16B_In) begin
                    burst_nx = bus.WD3_128_In;
                    base_nx  = bus.RegDest_In;
                    addr_nx  = bus.RegDest_In;
                    data_nx  = bus.WD3_128_In[31:0];
                    wr_nx    = (bus.RegDest_In != '0);
                    state_nx = B1;
                end else if (bus.RegWrite_In) begin
                    addr_nx = bus.RegDest_In;
                    data_nx = sel_data;
                    wr_nx   = (bus.RegDest_In != '0);
                end
`ifdef WB_AUX_PORT_EN
                // r0 target still acknowledges so the requester never wedges.
                else if (bus.AuxReq) begin
                    addr_nx = bus.AuxDest;
                    data_nx = bus.AuxData;
                    wr_nx   = (bus.AuxDest != '0);
                    ack_nx  = 1'b1;
                end
`endif
            end
            B1: begin
                addr_nx  = base_q + AW'(1);
                data_nx  = burst_q[63:32];
                wr_nx    = (addr_nx != '0);
                state_nx = B2;
            end
            B2: begin
                addr_nx  = base_q + AW'(2);
                data_nx  = burst_q[95:64];
                wr_nx    = (addr_nx != '0);
                state_nx = B3;
            end
            default: begin
                addr_nx  = base_q + AW'(3);
                data_nx  = burst_q[127:96];
                wr_nx    = (addr_nx != '0);
                state_nx = IDLE;
            end
        endcase

        stall_nx = (state_nx != IDLE);
    end

`ifndef WB_AUX_PORT_EN
    logic aux_unused;
    assign aux_unused = ^{bus.AuxReq, bus.AuxDest, bus.AuxData};
`endif

    assign bus.RFWrite = wr_q;
    assign bus.RFAddr  = addr_q;
    assign bus.RFData  = data_q;
    assign bus.AuxAck  = ack_q;
    assign bus.Stall   = stall_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Directed bench for wb_port_sequencer: scalar select, bursts, wrap/r0, aux arbitration, reset mid-burst.
module tb_wb_port_sequencer;

    localparam int AW = 5;

    logic       Clock;
    logic       Reset;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+31:0] exp_q[$];

    wb_port_sequencer_if #(.AW(AW)) bus ();

    wb_port_sequencer #(.AW(AW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every RF write observed mid-cycle must match the next expected write
    always @(negedge Clock) begin
        if (Reset && bus.RFWrite) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(bus.RFWrite), 64'd0);
            end else begin
                check("rf_write", 64'({bus.RFAddr, bus.RFData}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.RegWrite_In  = 1'b0;
        bus.L16B_In      = 1'b0;
        bus.MemToReg_In  = 2'd0;
        bus.RegDest_In   = '0;
        bus.ALUResult_In = '0;
        bus.ReadData_In  = '0;
        bus.PC_In        = '0;
        bus.WD3_128_In   = '0;
    endtask

    task automatic drive_scalar(input logic [AW-1:0] dest, input logic [1:0] m2r,
                                input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
        bus.RegWrite_In  = 1'b1;
        bus.L16B_In      = 1'b0;
        bus.MemToReg_In  = m2r;
        bus.RegDest_In   = dest;
        bus.ALUResult_In = alu;
        bus.ReadData_In  = rd;
        bus.PC_In        = pc;
    endtask

    task automatic drive_burst(input logic [AW-1:0] base, input logic [127:0] d);
        bus.RegWrite_In = 1'b1;
        bus.L16B_In     = 1'b1;
        bus.MemToReg_In = 2'd1;
        bus.RegDest_In  = base;
        bus.WD3_128_In  = d;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        Reset = 1'b0;
        drive_idle();
        bus.AuxReq  = 1'b0;
        bus.AuxDest = '0;
        bus.AuxData = '0;

        // reset state
        step();
        step();
        check("rst_rfwrite", 64'(bus.RFWrite), 64'd0);
        check("rst_stall",   64'(bus.Stall),   64'd0);
        check("rst_rfaddr",  64'(bus.RFAddr),  64'd0);
        check("rst_rfdata",  64'(bus.RFData),  64'd0);
        check("rst_auxack",  64'(bus.AuxAck),  64'd0);
        check("rst_state",   64'(state_dbg),   64'd0);
        Reset = 1'b1;
        step();

        // scalar writes through each MemToReg select
        drive_scalar(5'd5, 2'd0, 32'h1234, 32'hBEEF, 32'h40); expect_wr(5'd5, 32'h1234);
        step(); check("sc0_stall", 64'(bus.Stall), 64'd0);
        drive_scalar(5'd5, 2'd1, 32'h1234, 32'hBEEF, 32'h40); expect_wr(5'd5, 32'hBEEF);
        step(); check("sc1_stall", 64'(bus.Stall), 64'd0);
        drive_scalar(5'd5, 2'd2, 32'h1234, 32'hBEEF, 32'h40); expect_wr(5'd5, 32'h40);
        step(); check("sc2_stall", 64'(bus.Stall), 64'd0);
        drive_scalar(5'd6, 2'd3, 32'h77, 32'hBEEF, 32'h40);   expect_wr(5'd6, 32'h77);
        step(); check("sc3_wr", 64'(bus.RFWrite), 64'd1);
        drive_idle();
        step(); check("sc_idle_wr", 64'(bus.RFWrite), 64'd0);

        // L16B without RegWrite: nothing happens
        bus.L16B_In = 1'b1; bus.RegDest_In = 5'd9; bus.WD3_128_In = 128'h1;
        step();
        check("l16b_nowr_wr",    64'(bus.RFWrite), 64'd0);
        check("l16b_nowr_stall", 64'(bus.Stall),   64'd0);
        drive_idle();

        // burst r8..r11, then the held scalar on the fifth cycle
        drive_burst(5'd8, 128'h44444444_33333333_22222222_11111111);
        expect_wr(5'd8,  32'h11111111);
        expect_wr(5'd9,  32'h22222222);
        expect_wr(5'd10, 32'h33333333);
        expect_wr(5'd11, 32'h44444444);
        expect_wr(5'd12, 32'hABCD);
        step(); check("b_k0_stall", 64'(bus.Stall), 64'd1);
        check("b_k0_state", 64'(state_dbg), 64'd1);
        drive_scalar(5'd12, 2'd0, 32'hABCD, 32'h0, 32'h0);
        step(); check("b_k1_stall", 64'(bus.Stall), 64'd1);
        step(); check("b_k2_stall", 64'(bus.Stall), 64'd1);
        step(); check("b_k3_stall", 64'(bus.Stall), 64'd0);
        check("b_k3_addr", 64'(bus.RFAddr), 64'd11);
        step(); check("b_k4_addr", 64'(bus.RFAddr), 64'd12);
        check("b_k4_stall", 64'(bus.Stall), 64'd0);

        // back-to-back bursts: Stall low for exactly one cycle between them
        drive_burst(5'd16, 128'h00000004_00000003_00000002_00000001);
        expect_wr(5'd16, 32'h1); expect_wr(5'd17, 32'h2); expect_wr(5'd18, 32'h3); expect_wr(5'd19, 32'h4);
        step(); step(); step();
        check("bb_mid_stall", 64'(bus.Stall), 64'd1);
        drive_burst(5'd20, 128'h00000008_00000007_00000006_00000005);
        expect_wr(5'd20, 32'h5); expect_wr(5'd21, 32'h6); expect_wr(5'd22, 32'h7); expect_wr(5'd23, 32'h8);
        step(); check("bb_gap_stall", 64'(bus.Stall), 64'd0);
        step(); check("bb_2nd_stall", 64'(bus.Stall), 64'd1);
        check("bb_2nd_addr", 64'(bus.RFAddr), 64'd20);
        drive_idle();
        step(); step(); step();

        // wrap past r31 with r0 suppressed, then scalar to r0
        drive_burst(5'd30, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
        expect_wr(5'd30, 32'hAAAA0000);
        expect_wr(5'd31, 32'hBBBB0001);
        expect_wr(5'd1,  32'hDDDD0003);
        step(); drive_idle();
        step();
        step(); check("wrap_r0_wr",    64'(bus.RFWrite), 64'd0);
        check("wrap_r0_stall", 64'(bus.Stall), 64'd1);
        step(); check("wrap_r1_wr", 64'(bus.RFWrite), 64'd1);
        drive_scalar(5'd0, 2'd0, 32'h99, 32'h0, 32'h0);
        step(); check("scalar_r0_wr", 64'(bus.RFWrite), 64'd0);
        drive_idle();
        step();

        // aux request raised during a burst, followed by one more scalar
        drive_burst(5'd24, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        expect_wr(5'd24, 32'hA0A0A0A0); expect_wr(5'd25, 32'hA1A1A1A1);
        expect_wr(5'd26, 32'hA2A2A2A2); expect_wr(5'd27, 32'hA3A3A3A3);
        expect_wr(5'd20, 32'h5555);
        step();
        drive_scalar(5'd20, 2'd0, 32'h5555, 32'h0, 32'h0);
        bus.AuxReq = 1'b1; bus.AuxDest = 5'd3; bus.AuxData = 32'hCAFE;
        step(); check("aux_b1_ack", 64'(bus.AuxAck), 64'd0);
        step(); check("aux_b2_ack", 64'(bus.AuxAck), 64'd0);
        step(); check("aux_b3_ack", 64'(bus.AuxAck), 64'd0);
        step(); check("aux_sc_ack", 64'(bus.AuxAck), 64'd0);
        drive_idle();
`ifdef WB_AUX_PORT_EN
        expect_wr(5'd3, 32'hCAFE);
        step(); check("aux_grant_ack", 64'(bus.AuxAck), 64'd1);
        check("aux_grant_addr", 64'(bus.RFAddr), 64'd3);
        bus.AuxReq = 1'b0;
        step(); check("aux_after_ack", 64'(bus.AuxAck), 64'd0);
        check("aux_after_wr", 64'(bus.RFWrite), 64'd0);
`else
        step(); check("aux_off_ack", 64'(bus.AuxAck), 64'd0);
        check("aux_off_wr", 64'(bus.RFWrite), 64'd0);
        step(); check("aux_off_ack2", 64'(bus.AuxAck), 64'd0);
        bus.AuxReq = 1'b0;
`endif
        step();

        // reset asserted during B2 discards the remaining beats
        drive_burst(5'd12, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0);
        expect_wr(5'd12, 32'hF0F0F0F0);
        expect_wr(5'd13, 32'hF1F1F1F1);
        step(); drive_idle();
        step(); check("rmb_state_b2", 64'(state_dbg), 64'd2);
        @(negedge Clock); #1;
        Reset = 1'b0;
        #1;
        check("rmb_stall",   64'(bus.Stall),   64'd0);
        check("rmb_rfwrite", 64'(bus.RFWrite), 64'd0);
        check("rmb_rfaddr",  64'(bus.RFAddr),  64'd0);
        check("rmb_state",   64'(state_dbg),   64'd0);
        step(); step();
        Reset = 1'b1;
        step(); check("rmb_rel_wr", 64'(bus.RFWrite), 64'd0);
        drive_scalar(5'd7, 2'd1, 32'h0, 32'h7777, 32'h0); expect_wr(5'd7, 32'h7777);
        step(); check("rmb_post_stall", 64'(bus.Stall), 64'd0);
        check("rmb_post_addr", 64'(bus.RFAddr), 64'd7);
        drive_idle();
        step(); step();

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
